// File: rtl/fifo_8_16_pkg.sv
// Shared sizes and types for the 8-entry, 16-bit first-word-fall-through FIFO.
package fifo_8_16_pkg;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 3;
    localparam int COUNT_W = 4;

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [COUNT_W-1:0] count_t;
endpackage

// File: rtl/fifo_8_16_if.sv
// Producer/consumer handshake bundle for fifo_8_16; slave is the FIFO side.
interface fifo_8_16_if;
    import fifo_8_16_pkg::*;

    word_t  in_data;
    logic   in_valid;
    logic   in_ready;
    word_t  out_data;
    logic   out_valid;
    logic   out_ready;
    count_t count;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/dmux_8_way.sv
// Routes a single bit to one of eight outputs; all other outputs stay low.
module dmux_8_way
    import fifo_8_16_pkg::*;
(
    input  logic       i_in,
    input  ptr_t       i_sel,
    output logic [7:0] o_out
);
    always_comb begin
        o_out = 8'b0;
        o_out[i_sel] = i_in;
    end
endmodule

// File: rtl/mux_8_way_16.sv
// Eight-input, 16-bit combinational selector used as the FIFO read path.
module mux_8_way_16
    import fifo_8_16_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  word_t i_c,
    input  word_t i_d,
    input  word_t i_e,
    input  word_t i_f,
    input  word_t i_g,
    input  word_t i_h,
    input  ptr_t  i_sel,
    output word_t o_out
);
    always_comb begin
        o_out = i_a;
        case (i_sel)
            3'd0: o_out = i_a;
            3'd1: o_out = i_b;
            3'd2: o_out = i_c;
            3'd3: o_out = i_d;
            3'd4: o_out = i_e;
            3'd5: o_out = i_f;
            3'd6: o_out = i_g;
            3'd7: o_out = i_h;
            default: o_out = i_a;
        endcase
    end
endmodule

// File: rtl/fifo_8_16.sv
// 8x16 first-word-fall-through FIFO; full/empty are derived only from the
// occupancy counter so the independently wrapping pointers may be equal either way.
module fifo_8_16
    import fifo_8_16_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    fifo_8_16_if.slave    bus
);
    word_t      r_mem [DEPTH];
    ptr_t       r_wrPtr;
    ptr_t       r_rdPtr;
    count_t     r_count;

    logic       w_inReady;
    logic       w_outValid;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_loadEn;
    word_t      w_head;

    assign w_inReady  = (r_count != count_t'(DEPTH));
    assign w_outValid = (r_count != '0);
    assign w_push     = bus.in_valid & w_inReady;
    assign w_pop      = w_outValid & bus.out_ready;

    dmux_8_way u_loadDecode (
        .i_in  (w_push),
        .i_sel (r_wrPtr),
        .o_out (w_loadEn)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_loadEn[i]) r_mem[i] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    mux_8_way_16 u_readMux (
        .i_a   (r_mem[0]),
        .i_b   (r_mem[1]),
        .i_c   (r_mem[2]),
        .i_d   (r_mem[3]),
        .i_e   (r_mem[4]),
        .i_f   (r_mem[5]),
        .i_g   (r_mem[6]),
        .i_h   (r_mem[7]),
        .i_sel (r_rdPtr),
        .o_out (w_head)
    );

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out_data  = w_head;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_fifo_8_16.sv
// Scenario-per-task bench for fifo_8_16, checked against a queue model of the FIFO.
module tb_fifo_8_16;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] model [$];

    fifo_8_16_if ifc ();

    fifo_8_16 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck run still reports before stopping
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

    // One clock: decide accept/take from the model, then apply them after the edge
    task automatic tick();
        bit          doPush = ifc.in_valid && (model.size() < 8);
        bit          doPop  = ifc.out_ready && (model.size() > 0);
        logic [15:0] d      = ifc.in_data;
        @(posedge clk);
        #1;
        if (doPop)  void'(model.pop_front());
        if (doPush) model.push_back(d);
    endtask

    task automatic test_reset();
        ifc.in_data = '0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model.delete();
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", ifc.count); end
        checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", ifc.in_ready); end
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ifc.out_valid); end
        checks++; if (ifc.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0000", ifc.out_data); end
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 16'(16'h7700 + i);
            tick();
        end
        ifc.in_valid = 1'b0;
        checks++; if (ifc.count !== 4'd3) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 3", ifc.count); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL async_reset_count: got %0d expected 0", ifc.count); end
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_out_valid: got %b expected 0", ifc.out_valid); end
        checks++; if (ifc.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset_out_data: got %h expected 0000", ifc.out_data); end
        ifc.in_valid = 1'b1; ifc.in_data = 16'hBAD0;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL push_in_reset: got %0d expected 0", ifc.count); end
        reset_n = 1'b1;
        model.delete();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 16'(i + 1);
            tick();
        end
        checks++; if (ifc.count !== 4'd8) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 8", ifc.count); end
        checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_in_ready: got %b expected 0", ifc.in_ready); end
        ifc.in_data = 16'hDEAD;
        tick();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.count !== 4'd8) begin errors++; $display("[TB] FAIL overflow_count: got %0d expected 8", ifc.count); end
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (ifc.out_valid !== 1'b1 || ifc.out_data !== 16'(i + 1)) begin
                errors++; $display("[TB] FAIL drain_data[%0d]: got %h valid %b expected %h valid 1", i, ifc.out_data, ifc.out_valid, 16'(i + 1));
            end
            tick();
        end
        ifc.out_ready = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL drain_count: got %0d expected 0", ifc.count); end
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_out_valid: got %b expected 0", ifc.out_valid); end
    endtask

    task automatic test_wrap();
        int fullHits = 0;
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 16'($urandom);
            tick();
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        repeat (5) tick();
        ifc.out_ready = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL wrap_pre_count: got %0d expected 0", ifc.count); end
        for (int i = 0; i < 8; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 16'(16'hA000 + i);
            tick();
            if (ifc.count === 4'd8) fullHits++;
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (ifc.out_data !== 16'(16'hA000 + i)) begin
                errors++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, ifc.out_data, 16'(16'hA000 + i));
            end
            tick();
            if (ifc.count === 4'd8) fullHits++;
        end
        ifc.out_ready = 1'b0;
        checks++; if (fullHits !== 1) begin errors++; $display("[TB] FAIL wrap_full_hits: got %0d expected 1", fullHits); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 16'(16'h3000 + i);
            tick();
        end
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ifc.in_data = 16'(16'h3003 + k);
            checks++; if (ifc.out_data !== 16'(16'h3000 + k)) begin
                errors++; $display("[TB] FAIL simul_data[%0d]: got %h expected %h", k, ifc.out_data, 16'(16'h3000 + k));
            end
            tick();
            checks++; if (ifc.count !== 4'd3) begin errors++; $display("[TB] FAIL simul_count[%0d]: got %0d expected 3", k, ifc.count); end
        end
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifc.in_data = 16'(16'h4000 + i);
            tick();
        end
        checks++; if (ifc.count !== 4'd8) begin errors++; $display("[TB] FAIL simul_full_count: got %0d expected 8", ifc.count); end
        ifc.in_data = 16'hBEEF; ifc.out_ready = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.count !== 4'd7) begin errors++; $display("[TB] FAIL full_pop_count: got %0d expected 7", ifc.count); end
        checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_in_ready: got %b expected 1", ifc.in_ready); end
        checks++; if (ifc.out_data !== 16'h300B) begin errors++; $display("[TB] FAIL full_pop_head: got %h expected 300b", ifc.out_data); end
        for (int n = 0; n < 16 && model.size() > 0; n++) begin
            checks++; if (ifc.out_data !== model[0]) begin
                errors++; $display("[TB] FAIL simul_drain[%0d]: got %h expected %h", n, ifc.out_data, model[0]);
            end
            tick();
        end
        ifc.out_ready = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL simul_drain_count: got %0d expected 0", ifc.count); end
    endtask

    task automatic test_empty_latency();
        ifc.in_data = 16'h1234; ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.count !== 4'd1) begin errors++; $display("[TB] FAIL empty_no_pop_count: got %0d expected 1", ifc.count); end
        checks++; if (ifc.out_valid !== 1'b1 || ifc.out_data !== 16'h1234) begin
            errors++; $display("[TB] FAIL empty_latency_head: got %h valid %b expected 1234 valid 1", ifc.out_data, ifc.out_valid);
        end
        tick();
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL empty_pop_count: got %0d expected 0", ifc.count); end
        repeat (3) tick();
        ifc.out_ready = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("[TB] FAIL underflow_count: got %0d expected 0", ifc.count); end
        ifc.in_data = 16'h5678; ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.out_data !== 16'h5678) begin errors++; $display("[TB] FAIL underflow_rd_ptr: got %h expected 5678", ifc.out_data); end
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pushes = 0;
        int pops   = 0;
        for (int c = 0; c < 2000; c++) begin
            int pushBias = ((c / 250) % 2 == 0) ? 75 : 35;
            ifc.in_valid  = ($urandom_range(0, 99) < pushBias);
            ifc.out_ready = ($urandom_range(0, 99) < 55);
            ifc.in_data   = 16'($urandom);
            checks++; if (ifc.out_valid !== (model.size() != 0) || ifc.in_ready !== (model.size() != 8)) begin
                errors++; $display("[TB] FAIL rand_flags[%0d]: got valid %b ready %b expected valid %b ready %b",
                                   c, ifc.out_valid, ifc.in_ready, model.size() != 0, model.size() != 8);
            end
            if (model.size() > 0) begin
                checks++; if (ifc.out_data !== model[0]) begin
                    errors++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", c, ifc.out_data, model[0]);
                end
            end
            if (ifc.in_valid && model.size() < 8) pushes++;
            if (ifc.out_ready && model.size() > 0) pops++;
            tick();
            checks++; if (ifc.count !== 4'(pushes - pops)) begin
                errors++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", c, ifc.count, pushes - pops);
            end
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_empty_latency();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_8_16.md
Name: fifo_8_16

Overview:
- 8-entry, 16-bit first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Storage is eight 16-bit registers, written through a one-hot decode of the write pointer.
- The read word is selected combinationally by the existing mux_8_way_16, with select driven by the read pointer.
- Sits between a 16-bit word producer and any consumer that needs decoupling/buffering.

Parameters:
- WIDTH, 16, data word width. Fixed by the mux_8_way_16 read path; not overridable.
- DEPTH, 8, number of entries. Fixed by the 8-way read mux; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  16  word offered by the producer.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_data  output  16  word at the head of the FIFO.
- out_valid  output  1  out_data holds a valid head word.
- out_ready  input  1  consumer takes the head word this cycle.
- count  output  4  number of stored words, 0..8.

Behaviour:
- Reset and clocking:
  - One clock. Reset is asynchronous and active-low (reset_n).
  - While reset_n=0: wr_ptr=0, rd_ptr=0, count=0, all eight storage registers=16'h0000.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=16'h0000.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated at the rising edge of clk.
- Derived flags, all registered-state-derived:
  - in_ready = (count != 8).
  - out_valid = (count != 0).
  - There is no combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Write:
  - On push, mem[wr_ptr] <= in_data and wr_ptr <= wr_ptr+1 (3-bit, wraps 7 -> 0).
  - Write enables are a one-hot decode of wr_ptr, gated by push.
- Read:
  - out_data = mem[rd_ptr] through mux_8_way_16 (select = rd_ptr). Zero-cycle combinational path.
  - On pop, rd_ptr <= rd_ptr+1 (wraps 7 -> 0).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
  - neither: unchanged.
- Latency:
  - A word pushed at edge N is visible on out_data, with out_valid=1, after edge N (from cycle N+1).
  - There is no same-cycle bypass when empty.
- Full (count=8):
  - in_ready=0, and in_valid is ignored even if pop occurs that cycle.
  - in_ready rises the cycle after a pop.
- Empty (count=0):
  - out_valid=0, and out_ready is ignored.
  - out_data shows mem[rd_ptr], which is stale; the consumer must not use it.
- Ignored handshakes:
  - in_valid while in_ready=0 (overflow attempt): no state change.
  - out_ready while out_valid=0 (underflow attempt): no state change.
- Wrap-around:
  - Pointers wrap independently.
  - full/empty come only from count, never from pointer equality.
- Reset mid-operation:
  - Pointers, count and storage clear immediately (asynchronously).
  - In-flight data is discarded.
  - No push or pop is recognised while reset_n=0.
  - First push is possible at the first edge after reset_n rises.
- Storage registers change only on push. Read never alters storage.

Decomposition:
- Package fifo_8_16_pkg:
  - Constants: WIDTH=16, DEPTH=8, PTR_W=3, COUNT_W=4.
  - typedefs: word_t (logic[15:0]), ptr_t (logic[2:0]), count_t (logic[3:0]).
- Sub-modules:
  - Reuse mux_8_way_16 unchanged for the read path.
  - One new sub-module, dmux_8_way: 1-bit in, 3-bit select, 8 one-hot outputs. It generates the per-register load enables from push and wr_ptr.
- Pointer/count logic stays in the top module.

Test Plan:
- Reset and flags: hold reset_n=0 3 cycles, release -> count=0, in_ready=1, out_valid=0, out_data=16'h0000. Then assert reset_n=0 mid-cycle after 3 pushes -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
- Fill then drain:
  - Push 16'h0001..16'h0008 on 8 consecutive edges -> count=8, in_ready=0.
  - A 9th push of 16'hDEAD is ignored.
  - Drain 8 pops -> out_data sequence 0001..0008, then count=0, out_valid=0.
- Wrap-around:
  - Push 5 words, pop 5, then push 16'hA000..16'hA007 (8 words) -> wr_ptr wraps past 7.
  - Pops return A000..A007 in order; count reaches 8 exactly once.
- Simultaneous push and pop:
  - At count=3, hold in_valid=out_ready=1 for 10 cycles with an incrementing in_data -> count stays 3.
  - out_data follows push order with a 3-word lag.
  - At count=8, push is ignored while the pop succeeds -> count=7.
- Empty / latency:
  - At count=0, push 16'h1234 and assert out_ready in the same cycle -> no pop.
  - Next cycle out_valid=1, out_data=16'h1234; pop -> count=0.
  - out_ready with out_valid=0 leaves rd_ptr unchanged.
- Random back-pressure: 2000 cycles of random in_valid and out_ready -> the scoreboard queue matches the popped data, and count always equals pushes minus pops.
